// File: rtl/sram_ctrl_sp.sv
// sram_ctrl_sp: valid/ready front end for a single-port SRAM with a shared
// bidirectional data bus. Writes take one bus cycle; reads hold mem_oe for
// RD_WAIT+1 cycles and sample mem_data at the closing edge. TURN_CYCLES idle
// cycles follow every read so the RAM releases the bus before we drive it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (req_ready = IDLE && rst_n)
//   req_we/addr/wdata   request type, address, write data (latched on accept)
//   rsp_valid/rsp_we    one-cycle completion pulse and type of completed op
//   rsp_rdata           last read data, held until the next read completes
//   mem_addr/mem_data   SRAM address and bidirectional data bus
//   mem_cs/we/oe        SRAM strobes (registered)
module sram_ctrl_sp #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned RD_WAIT     = 1,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_e;

  localparam logic [3:0] RD_WAIT_L   = 4'(RD_WAIT);
  localparam logic [3:0] TURN_LAST_L = 4'(TURN_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;

  // Only the WRITE state drives the bus; every other state leaves it to the RAM.
  assign mem_data = (state_q == WRITE) ? wdata_q : 'z;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cs_d        = cs_q;
    we_d        = we_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cs_d   = 1'b1;
          if (req_we) begin
            state_d = WRITE;
            wdata_d = req_wdata;
            we_d    = 1'b1;
          end else begin
            state_d = READ;
            oe_d    = 1'b1;
            cnt_d   = RD_WAIT_L;
          end
        end
      end
      WRITE: begin
        cs_d        = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b1;
        state_d     = IDLE;
      end
      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d     = mem_data;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b0;
          cs_d        = 1'b0;
          oe_d        = 1'b0;
          if (TURN_CYCLES > 0) begin
            state_d = TURN;
            cnt_d   = TURN_LAST_L;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl_sp.sv
// Bench for sram_ctrl_sp: two controllers (RD_WAIT=1/TURN=1 and RD_WAIT=0/TURN=0),
// each attached to a behavioural single-port SRAM. Requests push expected
// responses into per-controller queues; a monitor pops and compares on rsp_valid.
module tb_sram_ctrl_sp;

  localparam int unsigned RDW0 = 1, TRN0 = 1, RDW1 = 0, TRN1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rv[2], rwe[2];
  logic [7:0] ra[2], rwd[2];
  logic       rdy[2], rsv[2], rswe[2], mcs[2], mwe[2], moe[2];
  logic [7:0] rsd[2], maddr[2];
  wire  [7:0] md0, md1;

  int unsigned cyc = 0;
  int unsigned passed = 0, total = 0;

  typedef struct {
    logic        we;
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  exp_t q0[$], q1[$];
  logic [7:0]  ref_mem[2][256];
  logic [7:0]  mem0[256], mem1[256];
  int unsigned iss_w[2], iss_r[2], got_w[2], got_r[2];
  int unsigned oe_run[2], last_oe[2];
  logic        seen_oe[2];

  sram_ctrl_sp #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_WAIT(RDW0), .TURN_CYCLES(TRN0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(rsv[0]), .rsp_we(rswe[0]),
    .rsp_rdata(rsd[0]), .mem_addr(maddr[0]), .mem_data(md0), .mem_cs(mcs[0]),
    .mem_we(mwe[0]), .mem_oe(moe[0]));

  sram_ctrl_sp #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_WAIT(RDW1), .TURN_CYCLES(TRN1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(rsv[1]), .rsp_we(rswe[1]),
    .rsp_rdata(rsd[1]), .mem_addr(maddr[1]), .mem_data(md1), .mem_cs(mcs[1]),
    .mem_we(mwe[1]), .mem_oe(moe[1]));

  // Single-port SRAM models: combinational read, write captured on the clock edge.
  assign md0 = (mcs[0] && moe[0] && !mwe[0]) ? mem0[maddr[0]] : 'z;
  assign md1 = (mcs[1] && moe[1] && !mwe[1]) ? mem1[maddr[1]] : 'z;
  always @(posedge clk) begin
    if (mcs[0] && mwe[0]) mem0[maddr[0]] <= md0;
    if (mcs[1] && mwe[1]) mem1[maddr[1]] <= md1;
  end

  always @(posedge clk) cyc++;

  function automatic int unsigned rdw(input int d);
    return (d == 0) ? RDW0 : RDW1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor plus bus-protocol watchers, all sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rsv[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("rsp_we", {31'd0, rswe[d]}, {31'd0, e.we});
          if (!e.we) chk("rsp_rdata", {24'd0, rsd[d]}, {24'd0, e.data});
          chk("rsp_cycle", cyc, e.due);
          if (rswe[d]) got_w[d]++;
          else         got_r[d]++;
        end
      end
      chk("we_oe_excl", {31'd0, moe[d] & mwe[d]}, 32'd0);
      if (moe[d]) begin
        oe_run[d]++;
        last_oe[d] = cyc;
        seen_oe[d] = 1'b1;
      end else if (oe_run[d] != 0) begin
        if (rst_n) chk("oe_len", oe_run[d], rdw(d) + 1);
        oe_run[d] = 0;
      end
      // Controller drives only while mem_we is high; require a full idle cycle after OE.
      if (mwe[d] && seen_oe[d])
        chk("turn_gap", {31'd0, (cyc - last_oe[d]) >= 2}, 32'd1);
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic issue(input int d, input logic we, input logic [7:0] a,
                       input logic [7:0] wd, output int unsigned acc);
    int   n;
    exp_t e;
    n = 0;
    rv[d] = 1'b1; rwe[d] = we; ra[d] = a; rwd[d] = wd;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      rv[d] = 1'b0;
      acc = 0;
      return;
    end
    acc    = cyc + 1;
    e.we   = we;
    e.data = we ? 8'h00 : ref_mem[d][a];
    e.due  = acc + 1 + (we ? 0 : rdw(d));
    if (we) begin ref_mem[d][a] = wd; iss_w[d]++; end
    else    iss_r[d]++;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    // Scramble request fields after accept; the op in flight must not notice.
    rv[d] = 1'b0; rwe[d] = ~we; ra[d] = ~a; rwd[d] = ~wd;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);
  endtask

  initial begin
    int unsigned a1, a2, a3, a4, prev;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00; mem1[i] = 8'h00;
      ref_mem[0][i] = 8'h00; ref_mem[1][i] = 8'h00;
    end
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; ra[d] = 8'h00; rwd[d] = 8'h00;
      iss_w[d] = 0; iss_r[d] = 0; got_w[d] = 0; got_r[d] = 0;
      oe_run[d] = 0; last_oe[d] = 0; seen_oe[d] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_ready",  {31'd0, rdy[0]}, 32'd0);
    chk("rst_cs",     {31'd0, mcs[0]}, 32'd0);
    chk("rst_addr",   {24'd0, maddr[0]}, 32'd0);
    chk("rst_rspv",   {31'd0, rsv[0]}, 32'd0);
    chk("rst_rdata",  {24'd0, rsd[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, rdy[0]}, 32'd1);
    @(negedge clk);

    // Write 0xA5 @0x10, read it back, then a pending write right behind the read.
    issue(0, 1'b1, 8'h10, 8'hA5, a1);
    issue(0, 1'b0, 8'h10, 8'h00, a2);
    issue(0, 1'b1, 8'h11, 8'h3C, a3);
    chk("wr_to_rd_interval", a2 - a1, 32'd2);
    chk("rd_to_wr_interval", a3 - a2, RDW0 + 2 + TRN0);
    drain();

    // Reset during the second READ cycle: op abandoned, bus released at once.
    issue(0, 1'b0, 8'h11, 8'h00, a1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs",    {31'd0, mcs[0]}, 32'd0);
    chk("midrst_oe",    {31'd0, moe[0]}, 32'd0);
    chk("midrst_we",    {31'd0, mwe[0]}, 32'd0);
    chk("midrst_ready", {31'd0, rdy[0]}, 32'd0);
    void'(q0.pop_back());
    iss_r[0]--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_release", {31'd0, rdy[0]}, 32'd1);
    prev = got_r[0] + got_w[0];
    repeat (4) @(negedge clk);
    chk("midrst_no_rsp", got_r[0] + got_w[0], prev);

    // Fill every address with addr^0x5A with req_valid held, then read all back.
    for (int i = 0; i < 256; i++) begin
      issue(0, 1'b1, 8'(i), 8'(i) ^ 8'h5A, a1);
      if (i > 0) chk("fill_wr_interval", a1 - prev, 32'd2);
      prev = a1;
    end
    for (int i = 0; i < 256; i++) begin
      issue(0, 1'b0, 8'(i), 8'h00, a1);
      if (i > 0) chk("fill_rd_interval", a1 - prev, RDW0 + 2 + TRN0);
      prev = a1;
    end
    drain();
    chk("sram_ff_content", {24'd0, mem0[255]}, 32'h000000A5);

    // Stall after a read of 0x77: outputs and address must hold.
    issue(0, 1'b1, 8'h20, 8'h77, a1);
    issue(0, 1'b0, 8'h20, 8'h00, a2);
    drain();
    for (int i = 0; i < 10; i++) begin
      chk("stall_rdata", {24'd0, rsd[0]}, 32'h77);
      chk("stall_strobes", {29'd0, mcs[0], mwe[0], moe[0]}, 32'd0);
      chk("stall_addr", {24'd0, maddr[0]}, 32'h20);
      @(negedge clk);
    end

    // RD_WAIT=0, TURN_CYCLES=0 controller.
    issue(1, 1'b1, 8'h05, 8'hC3, a1);
    issue(1, 1'b0, 8'h05, 8'h00, a2);
    issue(1, 1'b1, 8'hFF, 8'h99, a3);
    issue(1, 1'b0, 8'hFF, 8'h00, a4);
    chk("v_wr_rd_interval", a2 - a1, 32'd2);
    chk("v_rd_wr_interval", a3 - a2, 32'd2);
    chk("v_wr_rd2_interval", a4 - a3, 32'd2);
    drain();

    for (int d = 0; d < 2; d++) begin
      chk("wr_rsp_count", got_w[d], iss_w[d]);
      chk("rd_rsp_count", got_r[d], iss_r[d]);
    end
    chk("fill_wr_total", iss_w[0], 32'd259);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_sp.md
Name: sram_ctrl_sp

Overview:
Initiator for the team's single-port SRAM interface. That interface has a shared bidirectional data bus, chip select, write enable and output enable. Writes are captured by the RAM on the clock edge; reads are combinational. The controller converts a valid/ready request port from the core side into correctly sequenced SRAM cycles. It adds programmable read wait states and a bus-turnaround gap so the controller and the RAM never both drive the data bus.

Parameters:
DATA_WIDTH, 8, width of data bus and request/response data
ADDR_WIDTH, 8, width of SRAM address
RD_WAIT, 1, extra read wait cycles before sampling mem_data (legal 0..15)
TURN_CYCLES, 1, idle bus cycles inserted after every read (legal 0..3)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller accepts a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_we  output  1  type of the completed op
rsp_rdata  output  DATA_WIDTH  read data; holds until the next read completes
mem_addr  output  ADDR_WIDTH  SRAM address
mem_data  inout  DATA_WIDTH  SRAM bidirectional data
mem_cs  output  1  SRAM chip select
mem_we  output  1  SRAM write enable
mem_oe  output  1  SRAM output enable

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; mem_cs/mem_we/mem_oe=0; mem_addr=0; mem_data released to Z.
  - rsp_valid=0, rsp_we=0, rsp_rdata=0; req_ready=0 while rst_n is low.
  - An op in flight is abandoned with no response.
- Outputs are registered except req_ready, which equals (state==IDLE && rst_n).
- mem_data is driven with the wdata register only in state WRITE; it is Z in every other state.
- Handshake: a request is accepted at a rising edge where req_valid && req_ready. At that edge addr/wdata/we are latched.
- IDLE:
  - Accepted write -> WRITE, with mem_cs=1, mem_we=1, mem_oe=0.
  - Accepted read -> READ, with mem_cs=1, mem_we=0, mem_oe=1, and wait counter loaded with RD_WAIT.
- WRITE lasts exactly 1 cycle; the RAM captures data at its closing edge. At that edge:
  - mem_cs/mem_we <= 0.
  - rsp_valid <= 1, rsp_we <= 1.
  - state -> IDLE.
- READ lasts RD_WAIT+1 cycles.
  - At each edge with counter != 0: decrement.
  - At the edge with counter == 0: rsp_rdata <= mem_data, rsp_valid <= 1, rsp_we <= 0, mem_cs/mem_oe <= 0.
  - Then state -> TURN if TURN_CYCLES > 0, else IDLE.
- TURN lasts TURN_CYCLES cycles with all strobes 0 and the bus Z; then IDLE. req_ready=0 throughout.
- mem_addr holds the last latched address between ops (no glitching back to 0).
- Latency, with the accept edge as edge N:
  - Write: rsp_valid high for the cycle after edge N+1.
  - Read: rsp_valid high for the cycle after edge N+1+RD_WAIT.
- Throughput:
  - Back-to-back writes: one every 2 cycles.
  - Back-to-back reads: one every RD_WAIT+2+TURN_CYCLES cycles.
- req_* are ignored when not accepted; changes to req_* after the accept edge have no effect on the op in flight.
- mem_we and mem_oe are never both 1.
- Address wrap: none internally; the full ADDR_WIDTH range is usable, including all-ones.

Test Plan:
- Bench drives the team's single-port SRAM model (DATA_WIDTH=8, ADDR_WIDTH=8).
- Reset: assert rst_n low in the second READ cycle -> immediately mem_cs=mem_oe=0, mem_data=Z, req_ready=0; no rsp_valid after release; req_ready=1 first cycle after release.
- Write 0xA5 @0x10, then read 0x10 (RD_WAIT=1, TURN_CYCLES=1):
  - Write rsp_valid 1 cycle after WRITE.
  - Read: mem_oe high exactly 2 cycles; rsp_valid+rsp_rdata=0xA5 in the following cycle.
  - req_ready low 1 extra cycle (TURN).
- Read 0x10 immediately followed by pending write 0x3C @0x11 -> mem_data Z for ≥1 full cycle between mem_oe falling and the controller driving; no cycle with both mem_oe and mem_we high.
- Fill 0x00..0xFF with addr^0x5A using req_valid held continuously, then read all back:
  - Every rsp_rdata matches; 256 write and 256 read responses.
  - Write accept interval exactly 2 cycles; address 0xFF written/read correctly.
- Parameter variant RD_WAIT=0, TURN_CYCLES=0: read rsp_valid 1 cycle after the READ cycle; next request accepted on the cycle after READ ends.
- Stall: req_valid=0 for 10 cycles after a read of 0x77 -> rsp_rdata holds 0x77, all strobes 0, mem_addr unchanged.
